// File: rtl/ex_muldiv_pkg.sv
// Shared CPU definitions used by the Execute-stage multiply/divide unit.
//   muldiv_op_t  : 3-bit operation select driven by Execute
//   MULDIV_WIDTH : default operand/result width
//   is_mul_op()  : true for the operations served by the multiplier path
package cpu_defs;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    MUL   = 3'd0,
    MULH  = 3'd1,
    MULHU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MOD   = 3'd5,
    MODU  = 3'd6
  } muldiv_op_t;

  function automatic logic is_mul_op(input muldiv_op_t op);
    return (op == MUL) || (op == MULH) || (op == MULHU);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Execute <-> multiply/divide unit handshake.
//   master (Execute): drives is_flush, en, op, a, b; observes busy, done, out
//   slave  (unit)   : the reverse
interface ex_muldiv_if #(
  parameter int unsigned WIDTH = cpu_defs::MULDIV_WIDTH
);
  logic                 is_flush;
  logic                 en;
  cpu_defs::muldiv_op_t op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     out;

  modport master (
    output is_flush, en, op, a, b,
    input  busy, done, out
  );

  modport slave (
    input  is_flush, en, op, a, b,
    output busy, done, out
  );
endinterface

// File: rtl/ex_div_core.sv
// Radix-2 restoring divider datapath operating on unsigned magnitudes.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture dividend/divisor, clear partial remainder
//   step       : commit one iteration (one quotient bit)
//   dividend   : |a|
//   divisor    : |b|
//   quo_nxt    : quotient after the current iteration (combinational)
//   rem_nxt    : remainder after the current iteration (combinational)
module ex_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt,
  output logic [WIDTH-1:0] rem_nxt
);
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  // Two guard bits: the shifted remainder can reach 2^WIDTH when the
  // divisor has its top bit set, so the sign must sit above that.
  logic [WIDTH+1:0] trial;

  always_comb begin
    trial   = {1'b0, rem, quo[WIDTH-1]} - {2'b00, dvs};
    quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH+1]};
    if (trial[WIDTH+1]) begin
      rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
    end else begin
      rem_nxt = trial[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit for the Execute stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.is_flush, bus.en, bus.op, bus.a, bus.b : request from Execute
//   bus.busy : operation in flight
//   bus.done : one-cycle completion pulse
//   bus.out  : registered result, held until the next completion
module ex_muldiv
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH      = MULDIV_WIDTH,
  parameter int unsigned MUL_STAGES = 2
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  muldiv_op_t         op_q;
  logic [WIDTH-1:0]   a_q, b_q, out_q;
  logic               done_q, neg_q, neg_r;
  logic               op_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, prod_q;
  logic [WIDTH-1:0]   mul_res, div_res, a_mag, b_mag, quo_nxt, rem_nxt;

  assign op_signed = (op_q == MULH) || (op_q == DIV) || (op_q == MOD);

  // Multiplier: operands are stable from cycle 1, so stage k of the
  // delay chain is valid from cycle k+1; synthesis retimes these
  // registers into the array.
  assign a_ext = {{WIDTH{op_signed & a_q[WIDTH-1]}}, a_q};
  assign b_ext = {{WIDTH{op_signed & b_q[WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign prod_q = prod;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < MUL_STAGES - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= prod;
          for (int unsigned i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign prod_q = pipe[MUL_STAGES-2];
    end
  endgenerate

  assign mul_res = (op_q == MUL) ? prod_q[WIDTH-1:0] : prod_q[2*WIDTH-1:WIDTH];

  // Divider on magnitudes; signs are reapplied on the final iteration.
  assign a_mag = (op_signed && a_q[WIDTH-1]) ? ('0 - a_q) : a_q;
  assign b_mag = (op_signed && b_q[WIDTH-1]) ? ('0 - b_q) : b_q;

  ex_div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == S_DIV && cnt == '0),
    .step     (state == S_DIV && cnt != '0),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_comb begin
    if (op_q == DIV || op_q == DIVU) begin
      div_res = neg_q ? ('0 - quo_nxt) : quo_nxt;
    end else begin
      div_res = neg_r ? ('0 - rem_nxt) : rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= MUL;
      a_q    <= '0;
      b_q    <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.is_flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.en) begin
              op_q  <= bus.op;
              a_q   <= bus.a;
              b_q   <= bus.b;
              cnt   <= '0;
              state <= is_mul_op(bus.op) ? S_MUL : S_DIV;
            end
          end
          S_MUL: begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(MUL_STAGES - 1)) begin
              out_q  <= mul_res;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
          S_DIV: begin
            cnt <= cnt + CW'(1);
            if (cnt == '0) begin
              // Divide-by-zero keeps the all-ones quotient unsigned.
              neg_q <= op_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]) && (b_q != '0);
              neg_r <= op_signed && a_q[WIDTH-1];
            end
            if (cnt == CW'(WIDTH)) begin
              out_q  <= div_res;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy = (state == S_MUL) || (state == S_DIV);
  assign bus.done = done_q;
  assign bus.out  = out_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (WIDTH=32, MUL_STAGES=2) with a result scoreboard.
module tb_ex_muldiv;
  import cpu_defs::*;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  ex_muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample the current cycle at the falling edge, then move to the next cycle.
  task automatic tick();
    logic exp_done;
    exp_t e;
    @(negedge clk);
    exp_done = (sb.size() != 0) && (sb[0].cyc == cyc);
    if (exp_done || bus.done) begin
      check($sformatf("done_cyc%0d", cyc), {31'b0, bus.done}, {31'b0, exp_done});
      if (exp_done) begin
        e = sb.pop_front();
        check(e.tag, bus.out, e.val);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    exp_t e;
    bus.en = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    if (lat > 0) begin
      e.val = exp;
      e.cyc = cyc + lat;
      e.tag = tag;
      sb.push_back(e);
    end
    tick();
    bus.en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    check("drain_timeout", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    bus.en = 1'b0;
    bus.is_flush = 1'b0;
    bus.op = MUL;
    bus.a = '0;
    bus.b = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_done", {31'b0, bus.done}, 32'd0);
    check("reset_out", bus.out, 32'd0);
    rst_n = 1'b1;

    // Multiply family, done in cycle 3.
    issue(MUL, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFEB, 3, "mul");
    check("mul_busy_c1", {31'b0, bus.busy}, 32'd1);
    drain();
    issue(MULH, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 3, "mulh");
    drain();
    issue(MULHU, 32'hFFFFFFF9, 32'd3, 32'h00000002, 3, "mulhu");
    drain();

    // Back-to-back with en held high through the first operation.
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, "mulhu_max");
    bus.en = 1'b1;
    bus.op = MUL;
    bus.a  = 32'd6;
    bus.b  = 32'd7;
    sb.push_back('{val: 32'h0000002A, cyc: cyc + 6, tag: "mul_b2b"});
    repeat (4) tick();
    bus.en = 1'b0;
    drain();

    // Divide family, done in cycle 34.
    issue(DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "div_neg");
    check("div_busy_c1", {31'b0, bus.busy}, 32'd1);
    drain();
    issue(MOD,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "mod_neg");
    drain();
    issue(DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 34, "divu");
    drain();
    issue(DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34, "div_negb");
    drain();
    issue(MOD,  32'd100, 32'hFFFFFFF9, 32'h00000002, 34, "mod_negb");
    drain();
    issue(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "div_ovf");
    drain();
    issue(MOD,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, "mod_ovf");
    drain();
    issue(DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 34, "divu_z");
    drain();
    issue(DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 34, "div_z");
    drain();
    issue(MODU, 32'd5, 32'd0, 32'h00000005, 34, "modu_z");
    drain();
    issue(MOD,  32'd5, 32'd0, 32'h00000005, 34, "mod_z");
    drain();
    issue(DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 34, "div_negz");
    drain();
    issue(MOD,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 34, "mod_negz");
    drain();

    // Flush in cycle 10 of a divide; a fresh divide starts in cycle 11.
    issue(DIV, 32'd50, 32'd3, 32'd0, 0, "");
    repeat (9) tick();
    bus.is_flush = 1'b1;
    tick();
    bus.is_flush = 1'b0;
    check("flush_busy_c11", {31'b0, bus.busy}, 32'd0);
    issue(DIV, 32'd100, 32'd7, 32'd14, 34, "div_after_flush");
    drain();

    // Flush together with en in IDLE starts nothing.
    bus.is_flush = 1'b1;
    issue(MUL, 32'd2, 32'd2, 32'd0, 0, "");
    bus.is_flush = 1'b0;
    check("flush_en_busy", {31'b0, bus.busy}, 32'd0);
    repeat (5) tick();

    // Asynchronous reset in the middle of a multiply.
    issue(MUL, 32'd3, 32'd4, 32'd0, 0, "");
    check("mid_mul_busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_out", bus.out, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    issue(MUL, 32'd9, 32'd9, 32'd81, 3, "mul_after_rst");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit instantiated in the Execute stage. It replaces the fixed 32-bit multiplier and fills the pending divide path. The unit accepts one operation at a time and computes signed/unsigned low/high products and signed/unsigned quotients and remainders. It reports completion with a one-cycle `done` pulse, which Execute uses to drive `eu_stall`, and it aborts cleanly on pipeline flush.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 2.
- `MUL_STAGES`, 2: multiply latency in cycles, ≥ 1. Product registers are retimed across these stages.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `is_flush`  in  1: abort the in-flight operation and ignore `en` in the same cycle.
- `en`  in  1: start request. Execute drives `is_muldiv && !done`.
- `op`  in  `muldiv_op_t`: MUL, MULH, MULHU, DIV, DIVU, MOD, MODU.
- `a`, `b`  in  `WIDTH`: rj operand and rk operand (forwarded values).
- `busy`  out  1: operation in flight (states MUL, DIV).
- `done`  out  1: result valid. Exactly one cycle per accepted operation.
- `out`  out  `WIDTH`: registered result, valid while `done`.

## Operation
- FSM states are IDLE, MUL, DIV and DONE.
- IDLE: when `en` is high and `is_flush` is low, the unit latches `op`, `a` and `b` and clears the counter. It moves to MUL for MUL/MULH/MULHU, otherwise to DIV.
- MUL:
  - The counter increments each cycle.
  - When counter = `MUL_STAGES`-1, `out` is loaded and the unit goes to DONE.
  - MUL gives product[WIDTH-1:0]. MULH gives the signed×signed product[2W-1:W]. MULHU gives the unsigned product[2W-1:W].
- DIV:
  - Radix-2 restoring divider on magnitudes. It produces one quotient bit per cycle for `WIDTH` cycles.
  - The first DIV cycle latches |a|, |b| and the sign flags; iterations run on cycles 2..`WIDTH`+1.
  - Signed ops: the quotient is negated if sign(a)≠sign(b), and the remainder takes sign(a).
  - Divisor 0: quotient = all ones and remainder = `a`, for both signed and unsigned ops. No trap.
  - Signed overflow (a = MIN, b = −1): quotient = MIN, remainder = 0. This falls out of the magnitude arithmetic and needs no special case.
- DONE: `done` = 1 for one cycle, then the unit goes to IDLE. `en` is ignored in DONE.
- Flush: in any state, `is_flush` forces IDLE at the next edge. The counter clears and `done` stays 0. No partial result is visible.
- Reset (async, any state): state = IDLE, `busy` = 0, `done` = 0, `out` = 0, counter = 0. The unit is operational on the first edge after release.

## Timing
- Cycle 0 is the cycle in which `en` is high in IDLE.
- Multiply: `done` is high in cycle `MUL_STAGES`+1. `busy` is high in cycles 1..`MUL_STAGES`.
- Divide: `done` is high in cycle `WIDTH`+2, i.e. 34 for `WIDTH` = 32. Latency is fixed and independent of operand values.
- `out` holds its value after `done` until the next load.
- Back-to-back: if `en` is high again in the cycle after DONE, it is accepted as a new cycle 0. The minimum issue interval is latency + 1.
- `is_flush` and `en` high in the same IDLE cycle: no operation starts.
- `is_flush` high in the DONE cycle: `done` is still asserted in that cycle, because it is registered, and Execute masks it via `ex_flush`.
- Counter width is $clog2(`WIDTH`+2).

## Structure
- Shared package `cpu_defs`: `muldiv_op_t` enum (3 bits) and the `MULDIV_WIDTH` default.
- The FSM encoding stays local to the module.
- One sub-module, `ex_div_core`: the restoring iteration datapath (remainder/quotient shift registers, subtract/restore).
- `ex_muldiv` owns the FSM, the counter, the multiplier pipeline, sign handling and the output mux.

## Test plan
All scenarios use `WIDTH` = 32 and `MUL_STAGES` = 2.
- MUL/MULH/MULHU, a = 0xFFFFFFF9, b = 3:
  - MUL gives 0xFFFFFFEB.
  - MULH gives 0xFFFFFFFF.
  - MULHU gives 0x00000002.
  - `done` is high in cycle 3 only.
- MULHU with a = b = 0xFFFFFFFF gives 0xFFFFFFFE. With `en` held high, it is followed back-to-back by MUL 6×7, which gives 0x0000002A in cycle 7.
- Signed divide of −7 / 2:
  - DIV gives 0xFFFFFFFD.
  - MOD gives 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 gives 0x7FFFFFFC.
  - `done` is high in cycle 34.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000 and MOD gives 0x00000000.
- Divide by zero with a = 5, b = 0: DIVU and DIV give 0xFFFFFFFF; MODU and MOD give 0x00000005.
- Abort cases:
  - DIV started, then `is_flush` pulsed in cycle 10: `busy` = 0 in cycle 11 and there is no `done`.
  - A new DIV 100/7 started in cycle 11 returns 14 in cycle 45.
  - `rst_n` pulsed low mid-MUL: all outputs go to 0 immediately.
